// File: rtl/spram_arb_pkg.sv
`default_nettype none
// ============================================================================
// spram_arb_pkg : shared types and round-robin pick function
// Rev 1.0
// ============================================================================
package spram_arb_pkg;

  localparam int MAX_NREQ = 8;
  localparam int PTR_W    = $clog2(MAX_NREQ);

  // One-hot first set bit of req, scanning ptr, ptr+1, ... modulo n (n <= MAX_NREQ).
  function automatic logic [MAX_NREQ-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] req,
    input logic [PTR_W-1:0]    ptr,
    input int                  n
  );
    logic [MAX_NREQ-1:0] pick;
    logic                found;
    int                  idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if (k < n && !found && req[idx[PTR_W-1:0]]) begin
        pick[idx[PTR_W-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spram_core.sv
`default_nettype none
// ============================================================================
// spram_core : synchronous-read single-port RAM, array never reset
// Rev 1.0
// ============================================================================
module spram_core #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// spram_rr_arbiter : round-robin arbiter with burst lock sharing one SPRAM
// Rev 1.0
// ============================================================================
module spram_rr_arbiter
  import spram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 4,
  parameter int DW   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0]       prio_ptr;
  logic [IW-1:0]       lock_idx;
  logic                lock_vld;
  logic                rd_seen;
  logic [IW-1:0]       gnt_idx;
  logic [IW-1:0]       next_ptr;
  logic                any_gnt;
  logic                sel_we;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;
  logic [DW-1:0]       core_dout;
  logic [MAX_NREQ-1:0] req_ext;
  logic [MAX_NREQ-1:0] pick_ext;
  logic [PTR_W-1:0]    ptr_ext;
  logic                unused_pick;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    ptr_ext            = '0;
    ptr_ext[IW-1:0]    = prio_ptr;
    pick_ext           = rr_pick(req_ext, ptr_ext, NREQ);
    gnt                = '0;
    if (rst) begin
      gnt = '0;
    end else if (lock_vld && req[lock_idx]) begin
      gnt[lock_idx] = 1'b1;
    end else begin
      gnt = pick_ext[NREQ-1:0];
    end
  end

  assign unused_pick = ^pick_ext;

  always_comb begin
    gnt_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx   = IW'(i);
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
    any_gnt  = |gnt;
    next_ptr = (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + IW'(1);
  end

  // Pointer advances past the winner even while locked, so fairness resumes on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      rvalid   <= '0;
      rd_seen  <= 1'b0;
    end else begin
      rvalid <= '0;
      if (any_gnt) begin
        prio_ptr <= next_ptr;
        lock_vld <= lock[gnt_idx];
        lock_idx <= gnt_idx;
        if (!sel_we) begin
          rvalid  <= gnt;
          rd_seen <= 1'b1;
        end
      end else begin
        lock_vld <= 1'b0;
      end
    end
  end

  // The RAM output register has no reset; mask it until the first read after reset.
  assign rdata = rd_seen ? core_dout : '0;

  spram_core #(
    .AW (AW),
    .DW (DW)
  ) u_core (
    .clk  (clk),
    .en   (any_gnt),
    .we   (sel_we),
    .addr (sel_addr),
    .din  (sel_wdata),
    .dout (core_dout)
  );

endmodule
`default_nettype wire

// File: tb/tb_spram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_spram_rr_arbiter : directed scenarios plus randomized traffic vs a model
// Rev 1.0
// ============================================================================
module tb_spram_rr_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 4;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, we, lock;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]   gnt, rvalid;
  logic [DW-1:0]     rdata;

  logic [DW-1:0] m_mem [16];
  int            m_ptr;
  int            m_lock;
  logic [1:0]    m_rv;
  logic [7:0]    m_rd;
  int            n_checks = 0;
  int            n_pass   = 0;

  spram_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] model_gnt();
    int i;
    if (rst) return 2'b00;
    if (m_lock >= 0 && req[m_lock]) return 2'(1 << m_lock);
    for (int k = 0; k < NREQ; k++) begin
      i = (m_ptr + k) % NREQ;
      if (req[i]) return 2'(1 << i);
    end
    return 2'b00;
  endfunction

  task automatic set_req(input int i, input logic r, input logic w, input logic l,
                         input logic [3:0] a, input logic [7:0] d);
    req[i] = r; we[i] = w; lock[i] = l;
    addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d;
  endtask

  // Advance one clock and apply the behavioural rules to the model.
  task automatic tick();
    logic [1:0] g; int gi; logic gw, gl; logic [3:0] ga; logic [7:0] gd;
    g  = model_gnt();
    gi = g[1] ? 1 : 0;
    gw = we[gi]; gl = lock[gi]; ga = addr[gi*AW +: AW]; gd = wdata[gi*DW +: DW];
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_lock = -1; m_rv = 2'b00; m_rd = 8'h00;
    end else if (g != 2'b00) begin
      m_ptr  = (gi + 1) % NREQ;
      m_lock = gl ? gi : -1;
      if (gw) begin m_mem[ga] = gd; m_rv = 2'b00; end
      else begin m_rv = g; m_rd = m_mem[ga]; end
    end else begin
      m_rv = 2'b00; m_lock = -1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 2'b11; we = 2'b00; lock = 2'b00; addr = '0; wdata = '0;
    m_ptr = 0; m_lock = -1; m_rv = 2'b00; m_rd = 8'h00;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", gnt); else n_pass++;
      tick();
      n_checks++; if (rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", rvalid); else n_pass++;
      n_checks++; if (rdata !== 8'h00) $display("FAIL reset_rdata: got %h expected 00", rdata); else n_pass++;
    end
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 1'b0, 4'd0, 8'h11);
    set_req(1, 1'b1, 1'b1, 1'b0, 4'd1, 8'h22);
    #1;
    n_checks++; if (gnt !== 2'b01) $display("FAIL reset_first_gnt: got %b expected 01", gnt); else n_pass++;
    tick();
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    n_checks++; if (gnt !== 2'b10) $display("FAIL reset_second_gnt: got %b expected 10", gnt); else n_pass++;
    tick();
    req = 2'b00;
  endtask

  task automatic test_fill();
    for (int a = 0; a < 16; a++) begin
      set_req(0, 1'b1, 1'b1, 1'b0, 4'(a), 8'(a * 7 + 1));
      #1;
      n_checks++; if (gnt !== model_gnt()) $display("FAIL fill_gnt: got %b expected %b", gnt, model_gnt()); else n_pass++;
      tick();
    end
    req = 2'b00;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 1'b1, 1'b0, 4'd3, 8'hA5);
    #1;
    n_checks++; if (gnt !== 2'b01) $display("FAIL single_wr_gnt: got %b expected 01", gnt); else n_pass++;
    tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    #1;
    n_checks++; if (gnt !== 2'b01) $display("FAIL single_rd_gnt: got %b expected 01", gnt); else n_pass++;
    tick();
    req = 2'b00;
    n_checks++; if (rvalid !== 2'b01) $display("FAIL single_rvalid: got %b expected 01", rvalid); else n_pass++;
    n_checks++; if (rdata !== 8'hA5) $display("FAIL single_rdata: got %h expected a5", rdata); else n_pass++;
  endtask

  task automatic test_fairness();
    int cnt0, cnt1;
    cnt0 = 0; cnt1 = 0;
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
    #1; tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
    for (int k = 0; k < 8; k++) begin
      #1;
      n_checks++;
      if (gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10) || gnt !== model_gnt())
        $display("FAIL fair_gnt[%0d]: got %b expected %b", k, gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      else n_pass++;
      tick();
      cnt0 += int'(rvalid[0]); cnt1 += int'(rvalid[1]);
      n_checks++; if (rdata !== m_rd) $display("FAIL fair_rdata[%0d]: got %h expected %h", k, rdata, m_rd); else n_pass++;
    end
    req = 2'b00;
    n_checks++; if (cnt0 !== 4 || cnt1 !== 4) $display("FAIL fair_counts: got %0d/%0d expected 4/4", cnt0, cnt1); else n_pass++;
  endtask

  task automatic test_lock_burst();
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    #1; tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, 1'b1, 1'b1, 4'(4 + k), 8'(8'h10 + k));
      #1;
      n_checks++;
      if (gnt !== 2'b10 || gnt !== model_gnt()) $display("FAIL lock_gnt[%0d]: got %b expected 10", k, gnt);
      else n_pass++;
      tick();
    end
    set_req(1, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    n_checks++; if (gnt !== 2'b01) $display("FAIL lock_release_gnt: got %b expected 01", gnt); else n_pass++;
    tick();
    req = 2'b00;
    n_checks++; if (rvalid !== 2'b01) $display("FAIL lock_rvalid: got %b expected 01", rvalid); else n_pass++;
    n_checks++; if (rdata !== 8'h11) $display("FAIL lock_rdata: got %h expected 11", rdata); else n_pass++;
  endtask

  task automatic test_raw();
    set_req(0, 1'b1, 1'b1, 1'b0, 4'd9, 8'h3C);
    #1; tick();
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 4'd9, 8'h00);
    #1;
    n_checks++; if (gnt !== 2'b10) $display("FAIL raw_gnt: got %b expected 10", gnt); else n_pass++;
    tick();
    req = 2'b00;
    n_checks++; if (rvalid !== 2'b10) $display("FAIL raw_rvalid: got %b expected 10", rvalid); else n_pass++;
    n_checks++; if (rdata !== 8'h3C) $display("FAIL raw_rdata: got %h expected 3c", rdata); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [7:0] old2;
    old2 = m_mem[2];
    set_req(1, 1'b1, 1'b1, 1'b1, 4'd12, 8'h77);
    #1; tick();
    set_req(0, 1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
    set_req(1, 1'b1, 1'b1, 1'b1, 4'd13, 8'h78);
    #1;
    n_checks++; if (gnt !== 2'b10) $display("FAIL midrst_lock_gnt: got %b expected 10", gnt); else n_pass++;
    tick();
    set_req(1, 1'b1, 1'b0, 1'b1, 4'd12, 8'h00);
    #1; tick();
    rst = 1'b1;
    set_req(1, 1'b1, 1'b1, 1'b1, 4'd2, 8'hEE);
    #1;
    n_checks++; if (gnt !== 2'b00) $display("FAIL midrst_gnt: got %b expected 00", gnt); else n_pass++;
    tick();
    n_checks++; if (rvalid !== 2'b00) $display("FAIL midrst_rvalid: got %b expected 00", rvalid); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (gnt !== 2'b01) $display("FAIL midrst_next_gnt: got %b expected 01", gnt); else n_pass++;
    tick();
    n_checks++; if (rdata !== old2) $display("FAIL midrst_addr2: got %h expected %h", rdata, old2); else n_pass++;
    set_req(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
    #1; tick();
    req = 2'b00; lock = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0] g;
    for (int c = 0; c < 300; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 2) != 0)
          set_req(i, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, 15)), 8'($urandom));
      end
      #1;
      g = model_gnt();
      n_checks++; if (gnt !== g) $display("FAIL rand_gnt[%0d]: got %b expected %b", c, gnt, g); else n_pass++;
      tick();
      n_checks++; if (rvalid !== m_rv) $display("FAIL rand_rvalid[%0d]: got %b expected %b", c, rvalid, m_rv); else n_pass++;
      n_checks++; if (rdata !== m_rd) $display("FAIL rand_rdata[%0d]: got %h expected %h", c, rdata, m_rd); else n_pass++;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) begin
          if ($urandom_range(0, 1) == 0)
            set_req(i, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
          else
            set_req(i, 1'b1, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 0),
                    4'($urandom_range(0, 15)), 8'($urandom));
        end
      end
    end
    rst = 1'b0; req = 2'b00;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_single();
    test_fairness();
    test_lock_burst();
    test_raw();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
